mem_stage: RTL

Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and feeds `ALUResult_mem`, `rdAddr_mem` and `RegWrite_mem` back to the execute-stage forwarding logic. It runs loads and stores against a data memory over a req/ack handshake, which may take several cycles. It stalls the upstream pipeline until each access completes.

---
 rtl/mem_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: EX/MEM register, req/ack data-memory
// sequencer, store lane steering and load alignment/extension.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        MemtoReg_mem,
  output logic [31:0] MemDout_mem,
  output logic        MisAlign_mem,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [31:0] wdata_q;
  logic        regwrite_q;
  logic        memread_q;
  logic        memwrite_q;
  logic [2:0]  funct3_q;

  logic        mem_op;
  logic        misaligned;
  logic        aligned_op;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  // NOTE: every variable driven from always_comb gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    case (funct3_q)
      3'b001, 3'b101: misaligned = ALUResult_mem[0];
      3'b010:         misaligned = |ALUResult_mem[1:0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign mem_op       = memread_q | memwrite_q;
  assign aligned_op   = mem_op & ~misaligned;
  assign MisAlign_mem = mem_op & misaligned;
  assign RegWrite_mem = regwrite_q & ~MisAlign_mem;
  assign stall_mem    = aligned_op && (state != DONE);

  // Store data is replicated to every lane; the byte enables pick the live one.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = wdata_q;
    if (memwrite_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << ALUResult_mem[1:0];
          wdata_nxt = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be_nxt    = ALUResult_mem[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{wdata_q[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = wdata_q;
        end
      endcase
    end
  end

  assign rdata_shifted = dmem_rdata >> {ALUResult_mem[1:0], 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult_mem <= 32'h0;
      wdata_q       <= 32'h0;
      rdAddr_mem    <= 5'h0;
      regwrite_q    <= 1'b0;
      MemtoReg_mem  <= 1'b0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      funct3_q      <= 3'h0;
    end else if (!stall_mem) begin
      ALUResult_mem <= ALUResult_ex;
      wdata_q       <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
      regwrite_q    <= RegWrite_ex;
      MemtoReg_mem  <= MemtoReg_ex;
      memread_q     <= MemRead_ex;
      memwrite_q    <= MemWrite_ex;
      funct3_q      <= funct3_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_wdata  <= 32'h0;
      dmem_be     <= 4'h0;
      MemDout_mem <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned_op) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite_q;
            dmem_addr  <= {ALUResult_mem[31:2], 2'b00};
            dmem_wdata <= wdata_nxt;
            dmem_be    <= be_nxt;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (memread_q) MemDout_mem <= load_data;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
